// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmitter and receiver.
//   - uart_state_t     : frame state machine encoding (IDLE/START/DATA/PARITY/STOP)
//   - DEFAULT_CLK_FREQ : default system clock frequency in Hz
//   - DEFAULT_BAUD_RATE: default line rate in bit/s
//   - clks_per_bit()   : bit period in clock cycles (integer division)
//   - even_parity()    : parity bit that makes data plus parity carry an even
//                        number of ones
// ---------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int unsigned DEFAULT_CLK_FREQ  = 32'd50_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE = 32'd115_200;

    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

    function automatic logic even_parity(input logic [7:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter shared by the UART transmitter and receiver. Counts
// 0 .. CLKS_PER_BIT-1 and wraps; tick is high during the final cycle of each
// bit period.
// Ports:
//   clk   : system clock, rising edge
//   rst   : asynchronous, active-low reset
//   clear : hold the counter at 0 (next cycle is the first of a bit period)
//   tick  : registered, high in the last cycle of the current bit period
// ---------------------------------------------------------------------------
module uart_baud_gen #(
    parameter int unsigned CLKS_PER_BIT = 32'd434
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 32'd1) ? $clog2(CLKS_PER_BIT) : 32'd1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 32'd1);

    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic             tick_r;

    // Next counter value: hold at zero while cleared, otherwise count and wrap.
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (clear) begin
            cnt_nxt_s = '0;
        end else if (cnt_r == CNT_MAX) begin
            cnt_nxt_s = '0;
        end else begin
            cnt_nxt_s = cnt_r + CNT_W'(1'b1);
        end
    end

    // Counter and look-ahead tick register so tick lines up with CNT_MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= '0;
            tick_r <= 1'b0;
        end else begin
            cnt_r  <= cnt_nxt_s;
            tick_r <= (cnt_nxt_s == CNT_MAX);
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/uart_tx.sv
// ---------------------------------------------------------------------------
// uart_tx
// UART transmit serializer. Accepts one byte per tx_valid/tx_ready handshake
// and sends start bit, 8 data bits LSB first, optional even parity bit and
// STOP_BITS stop bits on serial_out (idle high).
//
// Build option: define UART_TX_PARITY_EN for 8E1/8E2 frames; when undefined
// the parity state and register are absent and frames are 8N1/8N2.
//
// Ports:
//   clk        : system clock, rising edge
//   rst        : asynchronous, active-low reset
//   tx_data    : byte to send, sampled only on the handshake cycle
//   tx_valid   : upstream has a byte (must be held until tx_ready)
//   tx_ready   : block is idle and will accept a byte
//   serial_out : registered UART line
//   busy       : frame in progress, always ~tx_ready
// ---------------------------------------------------------------------------
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = DEFAULT_CLK_FREQ,
    parameter int unsigned BAUD_RATE = DEFAULT_BAUD_RATE,
    parameter int unsigned STOP_BITS = 32'd1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       serial_out,
    output logic       busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam logic        STOP_LAST    = 1'(STOP_BITS - 32'd1);

    if (CLKS_PER_BIT < 32'd2) begin : g_bad_clks_per_bit
        $error("uart_tx: CLK_FREQ/BAUD_RATE must give at least 2 clocks per bit");
    end
    if ((STOP_BITS != 32'd1) && (STOP_BITS != 32'd2)) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_t state_r;
    uart_state_t state_nxt_s;
    logic [7:0]  shift_r;
    logic [7:0]  shift_nxt_s;
    logic [2:0]  idx_r;
    logic [2:0]  idx_nxt_s;
    logic        stop_cnt_r;
    logic        stop_cnt_nxt_s;
    logic        serial_out_r;
    logic        serial_nxt_s;
    logic        tx_ready_r;
    logic        baud_clear_s;
    logic        baud_tick_s;
`ifdef UART_TX_PARITY_EN
    logic        parity_r;
    logic        parity_nxt_s;
`endif

    // Every state change happens on a tick, when the counter wraps to zero on
    // its own, so holding it cleared in IDLE is enough to start each state
    // with a fresh count.
    assign baud_clear_s = (state_r == ST_IDLE);

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_gen (
        .clk   (clk),
        .rst   (rst),
        .clear (baud_clear_s),
        .tick  (baud_tick_s)
    );

    // Next-state, datapath and next line value.
    always_comb begin
        state_nxt_s    = state_r;
        shift_nxt_s    = shift_r;
        idx_nxt_s      = idx_r;
        stop_cnt_nxt_s = stop_cnt_r;
`ifdef UART_TX_PARITY_EN
        parity_nxt_s   = parity_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (tx_valid && tx_ready_r) begin
                    state_nxt_s    = ST_START;
                    shift_nxt_s    = tx_data;
                    idx_nxt_s      = 3'd0;
                    stop_cnt_nxt_s = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_nxt_s   = even_parity(tx_data);
`endif
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (baud_tick_s) begin
                    state_nxt_s = ST_DATA;
                    idx_nxt_s   = 3'd0;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (baud_tick_s) begin
                    shift_nxt_s = {1'b0, shift_r[7:1]};
                    idx_nxt_s   = idx_r + 3'd1;
                    if (idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_nxt_s    = ST_PARITY;
`else
                        state_nxt_s    = ST_STOP;
`endif
                        stop_cnt_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (baud_tick_s) begin
                    state_nxt_s    = ST_STOP;
                    stop_cnt_nxt_s = 1'b0;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
`endif
            ST_STOP: begin
                if (baud_tick_s) begin
                    if (stop_cnt_r == STOP_LAST) begin
                        state_nxt_s    = ST_IDLE;
                        stop_cnt_nxt_s = 1'b0;
                    end else begin
                        state_nxt_s    = ST_STOP;
                        stop_cnt_nxt_s = stop_cnt_r + 1'b1;
                    end
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        // The line is decoded from the next state so the registered output
        // changes on the same edge as the state register.
        case (state_nxt_s)
            ST_IDLE:   serial_nxt_s = 1'b1;
            ST_START:  serial_nxt_s = 1'b0;
            ST_DATA:   serial_nxt_s = shift_nxt_s[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: serial_nxt_s = parity_nxt_s;
`endif
            ST_STOP:   serial_nxt_s = 1'b1;
            default:   serial_nxt_s = 1'b1;
        endcase
    end

    // State, datapath and output registers; reset forces the line high at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= ST_IDLE;
            shift_r      <= 8'h00;
            idx_r        <= 3'd0;
            stop_cnt_r   <= 1'b0;
            serial_out_r <= 1'b1;
            tx_ready_r   <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            shift_r      <= shift_nxt_s;
            idx_r        <= idx_nxt_s;
            stop_cnt_r   <= stop_cnt_nxt_s;
            serial_out_r <= serial_nxt_s;
            tx_ready_r   <= (state_nxt_s == ST_IDLE);
`ifdef UART_TX_PARITY_EN
            parity_r     <= parity_nxt_s;
`endif
        end
    end

    assign serial_out = serial_out_r;
    assign tx_ready   = tx_ready_r;
    assign busy       = ~tx_ready_r;

endmodule

// File: tb/tb_uart_tx.sv
module tb_uart_tx;

    localparam int CPB = 434;
`ifdef UART_TX_PARITY_EN
    localparam int PBITS = 1;
`else
    localparam int PBITS = 0;
`endif

    typedef struct {
        logic [7:0] data;
        logic       par;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data,  tx_data2;
    logic       tx_valid, tx_valid2;
    logic       tx_ready, tx_ready2;
    logic       serial_out, serial_out2;
    logic       busy, busy2;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    uart_tx #(.STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .serial_out(serial_out), .busy(busy)
    );

    uart_tx #(.STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .tx_data(tx_data2), .tx_valid(tx_valid2),
        .tx_ready(tx_ready2), .serial_out(serial_out2), .busy(busy2)
    );

    function automatic logic line_of(input int sel);
        return (sel != 0) ? serial_out2 : serial_out;
    endfunction

    function automatic logic rdy_of(input int sel);
        return (sel != 0) ? tx_ready2 : tx_ready;
    endfunction

    function automatic logic bsy_of(input int sel);
        return (sel != 0) ? busy2 : busy;
    endfunction

    task automatic set_in(input int sel, input logic v, input logic [7:0] d);
        if (sel != 0) begin
            tx_valid2 = v;
            tx_data2  = d;
        end else begin
            tx_valid = v;
            tx_data  = d;
        end
    endtask

    // Raise valid, wait for ready, let the handshake edge pass.
    task automatic start_frame(input int sel, input logic [7:0] d, input bit keep);
        int n = 0;
        set_in(sel, 1'b1, d);
        while (rdy_of(sel) !== 1'b1 && n < 20000) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20000) begin
            checks++;
            failures++;
            $display("FAIL hs_timeout: tx_ready=%b after %0d cycles, want 1", rdy_of(sel), n);
        end
        @(posedge clk); #1;
        if (!keep) set_in(sel, 1'b0, 8'($urandom));
    endtask

    // Reference frame: start, data LSB first, optional parity, stop bits;
    // each bit held for CPB cycles, then ready must be back in the next cycle.
    task automatic check_frame(input int sel, input logic [7:0] d, input logic par,
                               input int nstop, input string name);
        logic exp_q[$];
        int   bad;
        logic got;
        exp_q.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_q.push_back(d[i]);
        if (PBITS == 1) exp_q.push_back(par);
        for (int s = 0; s < nstop; s++) exp_q.push_back(1'b1);
        for (int b = 0; b < exp_q.size(); b++) begin
            bad = 0;
            got = exp_q[b];
            for (int k = 0; k < CPB; k++) begin
                @(negedge clk);
                if (line_of(sel) !== exp_q[b] || rdy_of(sel) !== 1'b0 || bsy_of(sel) !== 1'b1) begin
                    bad++;
                    got = line_of(sel);
                end
            end
            checks++;
            if (bad != 0) begin
                failures++;
                $display("FAIL %s bit%0d: %0d bad cycles, line=%b want=%b (ready must be 0)",
                         name, b, bad, got, exp_q[b]);
            end
        end
        @(negedge clk);
        checks++;
        if (line_of(sel) !== 1'b1 || rdy_of(sel) !== 1'b1 || bsy_of(sel) !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_rise: line=%b ready=%b busy=%b, want 1 1 0",
                     name, line_of(sel), rdy_of(sel), bsy_of(sel));
        end
    endtask

    initial begin
        vec_t       tbl[4];
        logic [7:0] d;
        int         bad;

        tbl[0] = '{data: 8'hA5, par: 1'b0};
        tbl[1] = '{data: 8'h07, par: 1'b1};
        tbl[2] = '{data: 8'h01, par: 1'b1};
        tbl[3] = '{data: 8'h7F, par: 1'b1};

        rst = 1'b0;
        tx_valid = 1'b0; tx_data = 8'h00;
        tx_valid2 = 1'b0; tx_data2 = 8'h00;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        checks++;
        if (serial_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL reset: line=%b ready=%b busy=%b, want 1 1 0", serial_out, tx_ready, busy);
        end
        checks++;
        if (serial_out2 !== 1'b1 || tx_ready2 !== 1'b1 || busy2 !== 1'b0) begin
            failures++;
            $display("FAIL reset2: line=%b ready=%b busy=%b, want 1 1 0", serial_out2, tx_ready2, busy2);
        end
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Table-driven frames.
        for (int v = 0; v < 4; v++) begin
            start_frame(0, tbl[v].data, 1'b0);
            check_frame(0, tbl[v].data, tbl[v].par, 1, $sformatf("vec%0d", v));
        end

        // Back-to-back with tx_valid held: second start exactly one cycle after ready.
        start_frame(0, 8'h00, 1'b1);
        tx_data = 8'hFF;
        check_frame(0, 8'h00, 1'b0, 1, "b2b_first");
        fork
            check_frame(0, 8'hFF, 1'b0, 1, "b2b_second");
            begin
                @(posedge clk); #1;
                tx_valid = 1'b0;
            end
        join

        // tx_valid toggled with 0x3C mid-frame: no effect, nothing queued.
        start_frame(0, 8'h18, 1'b0);
        fork
            check_frame(0, 8'h18, 1'b0, 1, "toggle");
            begin
                repeat (50) begin
                    @(posedge clk); #1;
                    tx_valid = 1'($urandom_range(0, 1));
                    tx_data  = 8'h3C;
                end
                tx_valid = 1'b0;
            end
        join
        bad = 0;
        for (int k = 0; k < 2 * CPB; k++) begin
            @(negedge clk);
            if (serial_out !== 1'b1 || tx_ready !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL no_extra_frame: %0d cycles not idle, want 0", bad);
        end

        // Reset during data bit 4 of 0xC3 (bit 4 is 0).
        start_frame(0, 8'hC3, 1'b0);
        repeat (5 * CPB + 200) @(negedge clk);
        checks++;
        if (serial_out !== 1'b0 || tx_ready !== 1'b0) begin
            failures++;
            $display("FAIL pre_rst_bit4: line=%b ready=%b, want 0 0", serial_out, tx_ready);
        end
        #1 rst = 1'b0;
        #1;
        checks++;
        if (serial_out !== 1'b1 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL async_rst: line=%b ready=%b busy=%b, want 1 1 0", serial_out, tx_ready, busy);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        start_frame(0, 8'h5A, 1'b0);
        check_frame(0, 8'h5A, 1'b0, 1, "post_rst");

        // Random bytes with random idle gaps against the frame model.
        for (int r = 0; r < 4; r++) begin
            d = 8'($urandom);
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            start_frame(0, d, 1'b0);
            check_frame(0, d, 1'(($countones(d) % 2) == 1), 1, $sformatf("rand%0d_%02h", r, d));
        end

        // Two stop bits.
        start_frame(1, 8'h81, 1'b0);
        check_frame(1, 8'h81, 1'b0, 2, "stop2");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
